// File: rtl/vga_pkg.sv
// Shared VGA pixel-pipeline constants and types.
// The mouse simulator uses the same cursor reset position.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    typedef logic [9:0] coord_t;
    typedef logic [2:0] rgb_t;

    localparam rgb_t RGB_BLACK = 3'b000;
    localparam rgb_t RGB_WHITE = 3'b111;
    localparam rgb_t RGB_RED   = 3'b100;

    localparam coord_t CUR_RESET_X = 10'd360;
    localparam coord_t CUR_RESET_Y = 10'd200;

    // Signed 11-bit difference of two unsigned coordinates (no wrap-around)
    function automatic logic signed [10:0] coord_diff(input coord_t a, input coord_t b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

endpackage

// File: rtl/cursor_overlay_if.sv
// Pixel stream into the overlay stage and the coloured stream out to the DAC registers.
interface cursor_overlay_if;
    import vga_pkg::*;

    logic   frame_start;
    logic   pix_valid;
    coord_t pix_x;
    coord_t pix_y;
    rgb_t   bg_rgb;
    rgb_t   rgb_out;
    logic   rgb_valid;

    modport master (
        output frame_start, pix_valid, pix_x, pix_y, bg_rgb,
        input  rgb_out, rgb_valid
    );

    modport slave (
        input  frame_start, pix_valid, pix_x, pix_y, bg_rgb,
        output rgb_out, rgb_valid
    );

endinterface

// File: rtl/crosshair_hit.sv
// Combinational crosshair hit test: a plus shape of half-length ARM centred on (cur_x, cur_y).
module crosshair_hit
    import vga_pkg::*;
#(
    parameter int ARM = 7
) (
    input  coord_t pix_x,
    input  coord_t pix_y,
    input  coord_t cur_x,
    input  coord_t cur_y,
    output logic   hit
);

    localparam logic signed [10:0] ARM_S = 11'(ARM);

    logic signed [10:0] dx_s;
    logic signed [10:0] dy_s;
    logic               in_area_s;
    logic               on_h_s;
    logic               on_v_s;

    // Distance compare against both arms; off-screen pixels never hit
    always_comb begin
        dx_s      = coord_diff(pix_x, cur_x);
        dy_s      = coord_diff(pix_y, cur_y);
        in_area_s = (32'(pix_x) < H_ACTIVE) && (32'(pix_y) < V_ACTIVE);
        on_h_s    = (dy_s == 11'sd0) && (dx_s >= -ARM_S) && (dx_s <= ARM_S);
        on_v_s    = (dx_s == 11'sd0) && (dy_s >= -ARM_S) && (dy_s <= ARM_S);
        hit       = in_area_s && (on_h_s || on_v_s);
    end

endmodule

// File: rtl/cursor_overlay.sv
// Two-stage pixel pipeline drawing a crosshair cursor over the background stream.
// Cursor position is latched once per frame so a moving cursor never tears.
module cursor_overlay
    import vga_pkg::*;
#(
    parameter int ARM          = 7,
    parameter int BLINK_FRAMES = 15
) (
    input  logic   clk_in,
    input  logic   rst_in,
    input  coord_t x_pos,
    input  coord_t y_pos,
    input  logic   click_in,
    cursor_overlay_if.slave pix
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    coord_t           cur_x_r;
    coord_t           cur_y_r;
    logic [CNT_W-1:0] frame_cnt_r;
    logic             blink_on_r;

    logic             hit_s;
    logic             hit_r;
    rgb_t             bg_r;
    logic             valid_r;
    logic             click_r;
    logic             blink_r;

    rgb_t             rgb_next_s;
    rgb_t             rgb_r;
    logic             rgb_valid_r;

    crosshair_hit #(.ARM(ARM)) u_hit (
        .pix_x (pix.pix_x),
        .pix_y (pix.pix_y),
        .cur_x (cur_x_r),
        .cur_y (cur_y_r),
        .hit   (hit_s)
    );

    // Per-frame position latch; the pulse-cycle pixel still sees the old value
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cur_x_r <= CUR_RESET_X;
            cur_y_r <= CUR_RESET_Y;
        end else if (pix.frame_start) begin
            cur_x_r <= x_pos;
            cur_y_r <= y_pos;
        end
    end

    // Blink phase: toggles every BLINK_FRAMES frames while the button is held
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            frame_cnt_r <= '0;
            blink_on_r  <= 1'b1;
        end else if (!click_in) begin
            frame_cnt_r <= '0;
            blink_on_r  <= 1'b1;
        end else if (pix.frame_start) begin
            if (frame_cnt_r == CNT_LAST) begin
                frame_cnt_r <= '0;
                blink_on_r  <= ~blink_on_r;
            end else begin
                frame_cnt_r <= frame_cnt_r + 1'b1;
            end
        end
    end

    // Stage 1: hit result plus everything the colour mux needs, sampled together
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_r   <= 1'b0;
            bg_r    <= RGB_BLACK;
            valid_r <= 1'b0;
            click_r <= 1'b0;
            blink_r <= 1'b1;
        end else begin
            hit_r   <= hit_s & pix.pix_valid;
            bg_r    <= pix.bg_rgb;
            valid_r <= pix.pix_valid;
            click_r <= click_in;
            blink_r <= blink_on_r;
        end
    end

    // Colour select; a hidden blinking cursor shows the background
    always_comb begin
        rgb_next_s = RGB_BLACK;
        if (!valid_r) begin
            rgb_next_s = RGB_BLACK;
        end else if (hit_r && !click_r) begin
            rgb_next_s = RGB_WHITE;
        end else if (hit_r && blink_r) begin
            rgb_next_s = RGB_RED;
        end else begin
            rgb_next_s = bg_r;
        end
    end

    // Stage 2: registered outputs toward the DAC
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rgb_r       <= RGB_BLACK;
            rgb_valid_r <= 1'b0;
        end else begin
            rgb_r       <= rgb_next_s;
            rgb_valid_r <= valid_r;
        end
    end

    assign pix.rgb_out   = rgb_r;
    assign pix.rgb_valid = rgb_valid_r;

endmodule

// File: doc/cursor_overlay.md
# cursor_overlay

Pixel-pipeline stage that consumes the cursor position produced by the button-driven mouse simulator (or a future PS/2 decoder) and draws a crosshair cursor over the VGA background stream. It latches `x_pos`/`y_pos` once per frame to avoid tearing, compares every active pixel against a 15×15 crosshair centred on the latched position, and outputs the cursor colour or the background colour. It sits between the VGA timing/background generator and the DAC output registers.

## Interface
- `ARM`, default 7: crosshair half-length in pixels; the total span is 2·ARM+1.
- `BLINK_FRAMES`, default 15: frames per blink half-period while `click_in` is high.
- `clk_in`, in, 1: pixel clock. All logic is on the rising edge.
- `rst_in`, in, 1: reset. One clock; reset is asynchronous and active-high.
- `x_pos`, in, 10: cursor column, from the mouse simulator.
- `y_pos`, in, 10: cursor row, from the mouse simulator.
- `frame_start`, in, 1: one-cycle pulse in the first active pixel cycle of a frame.
- `pix_valid`, in, 1: the current cycle carries an active pixel.
- `pix_x`, in, 10: active column, 0..639.
- `pix_y`, in, 10: active row, 0..479.
- `bg_rgb`, in, 3: background colour for this pixel.
- `click_in`, in, 1: button held; selects the blinking red cursor.
- `rgb_out`, out, 3: output colour.
- `rgb_valid`, out, 1: `pix_valid` delayed by 2 cycles.

## Operation
- **Position latch.** `cur_x`/`cur_y` load `x_pos`/`y_pos` on the cycle `frame_start`=1.
  - Reset value: 360/200, matching the simulator power-up position.
  - Values are latched unclamped. Positions at or beyond 640/480 simply produce no visible hit.
- **Hit test** (signed 11-bit arithmetic):
  - dx = pix_x − cur_x; dy = pix_y − cur_y.
  - hit = pix_valid ∧ ((dy=0 ∧ |dx|≤ARM) ∨ (dx=0 ∧ |dy|≤ARM)).
  - Parts of the crosshair that fall outside the active area are not drawn. There is no wrap-around.
- **Blink counter.**
  - `frame_cnt` counts `frame_start` pulses modulo BLINK_FRAMES.
  - `blink_on` toggles on each wrap from BLINK_FRAMES−1 to 0.
  - `click_in`=0 forces `blink_on`=1 and `frame_cnt`=0.
  - Reset: `frame_cnt`=0, `blink_on`=1.
- **Colour select.**
  - hit ∧ ¬click: 3'b111.
  - hit ∧ click ∧ `blink_on`: 3'b100.
  - hit ∧ click ∧ ¬`blink_on`: `bg_rgb` (cursor hidden).
  - No hit: `bg_rgb`.
  - `pix_valid`=0: 3'b000 (blanking).

## Timing
- **Pipeline.** Stage 1 registers dx/dy compare results, `bg_rgb` and `pix_valid`. Stage 2 registers `rgb_out` and `rgb_valid`.
  - Latency is fixed at 2 cycles; one pixel is accepted per cycle with no stall.
- **Latch timing.** When `frame_start` is sampled high in cycle N:
  - the pixel in cycle N uses the old `cur_x`/`cur_y`;
  - pixels from N+1 onward use the new value.
  - The blink counter updates in the same cycle N.
- **Position stability.** `x_pos`/`y_pos` changes between `frame_start` pulses have no visible effect until the next pulse.
- **Reset.** Reset at any point clears both pipeline stages: `rgb_out`=0 and `rgb_valid`=0 on assertion. The first valid output appears 2 cycles after the first `pix_valid` following deassertion.
- **Stale `click_in`.** `click_in` is sampled in stage 1 alongside the pixel. A change affects pixels presented from that cycle on.

## Structure
- **Shared package `vga_pkg`** holds:
  - H_ACTIVE=640, V_ACTIVE=480;
  - colour constants RGB_BLACK, RGB_WHITE, RGB_RED;
  - CUR_RESET_X=360, CUR_RESET_Y=200. The simulator uses the same reset constants.
- **Sub-module `crosshair_hit`** (combinational): takes pix_x, pix_y, cur_x, cur_y and ARM, and returns hit. It is reusable for future sprite shapes.

## Test plan
- **Reset, no frame_start.** Apply reset, then stream a frame with no `frame_start` → hit pixels at (353..367, 200) and (360, 193..207), white; `rgb_out`=bg everywhere else; `rgb_valid` lags `pix_valid` by 2.
- **Latch boundary.** x_pos=100, y_pos=50 changes mid-frame → the current frame still draws at 360/200. After the next `frame_start`, (93,50) and (100,43) are white and (92,50) is bg. The pixel coincident with `frame_start` uses the old position.
- **Edge clipping.** x_pos=639, y_pos=479 → only (632..639, 479) and (639, 472..479) are hit. No hit at column 0 or row 0.
- **Blink.** `click_in`=1 for 40 frames with BLINK_FRAMES=15 → red for frames 0–14, bg for 15–29, red for 30–39. Releasing click → white on the next pixel.
- **Reset mid-line.** Assert `rst_in` mid-line → `rgb_out`=0 and `rgb_valid`=0 asynchronously. `cur_x`/`cur_y` return to 360/200; output resumes 2 cycles after `pix_valid` returns.
- **Blanking.** `pix_valid`=0 with `pix_x`/`pix_y` equal to the cursor position → `rgb_out`=000 and `rgb_valid`=0.
